// File: rtl/axi_sram_slave_pkg.sv
// Shared definitions for the AXI SRAM slave: FSM encodings, AXI burst and
// response codes, and a burst-stepping helper.
package axi_sram_slave_pkg;

    // Read channel FSM states
    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Write channel FSM states
    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_t;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // AXI burst types; WRAP is treated exactly like INCR
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Every burst type except FIXED steps the word index after each beat
    function automatic logic burst_steps(input logic [1:0] burst);
        return (burst != BURST_FIXED);
    endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI read/write channel bundle between an AXI master and the SRAM slave.
interface axi_sram_slave_if;

    // Read address channel
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    // Read data channel
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    // Write address channel
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    // Write data channel
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    // Write response channel
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

endinterface

// File: rtl/axi_sram_slave_sram_bytewise.sv
// Byte-writable word memory: one synchronous write port with per-byte
// enables and one asynchronous read port. Contents are not affected by reset.
module sram_bytewise #(
    parameter int DEPTH_LOG2 = 10,
    parameter int INIT_ZERO  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [3:0]            i_be,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [31:0]           o_rdata
);

    localparam int          DEPTH    = 1 << DEPTH_LOG2;
    // Power-up value of every word; only meaningful when INIT_ZERO is set
    localparam logic [31:0] MEM_INIT = (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx;

    logic [31:0] r_mem [DEPTH] = '{default: MEM_INIT};

    // Write only the byte lanes whose enable is set
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we && i_be[b]) begin
                r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    // Read port sees the stored value before any write on the same edge
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI slave in front of a byte-writable SRAM. Independent read and write
// FSMs; FIXED bursts hold the word index, INCR and WRAP step it linearly and
// wrap modulo the memory depth. Address bits above the memory size alias.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int INIT_ZERO  = 1
) (
    input  logic            aclk,
    input  logic            aresetn,
    axi_sram_slave_if.slave io_axi
);

    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    // Read channel state
    rd_state_t             r_rstate;
    logic [3:0]            r_rid;
    logic [DEPTH_LOG2-1:0] r_ridx;
    logic [3:0]            r_rlen;
    logic [1:0]            r_rburst;
    logic [3:0]            r_rbeat;

    // Write channel state
    wr_state_t             r_wstate;
    logic [3:0]            r_bid;
    logic [DEPTH_LOG2-1:0] r_widx;
    logic [3:0]            r_wlen;
    logic [1:0]            r_wburst;
    logic [3:0]            r_wbeat;
    logic [1:0]            r_bresp;

    logic        w_mem_we;
    logic [31:0] w_mem_rdata;
    logic        w_wbeat_last;
    logic        w_unused;

    assign w_mem_we     = (r_wstate == W_DATA) && io_axi.wvalid;
    assign w_wbeat_last = (r_wbeat == r_wlen);

    // Byte offset and aliased upper address bits carry no information here
    assign w_unused = ^{io_axi.araddr[31:DEPTH_LOG2+2], io_axi.araddr[1:0],
                        io_axi.awaddr[31:DEPTH_LOG2+2], io_axi.awaddr[1:0]};

    sram_bytewise #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_ZERO  (INIT_ZERO)
    ) u_mem (
        .i_clk   (aclk),
        .i_we    (w_mem_we),
        .i_be    (io_axi.wstrb),
        .i_waddr (r_widx),
        .i_wdata (io_axi.wdata),
        .i_raddr (r_ridx),
        .o_rdata (w_mem_rdata)
    );

    // Read FSM: accept AR in idle, stream beats from the latched index
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate <= R_IDLE;
            r_rid    <= 4'd0;
            r_ridx   <= '0;
            r_rlen   <= 4'd0;
            r_rburst <= BURST_FIXED;
            r_rbeat  <= 4'd0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (io_axi.arvalid) begin
                        r_rid    <= io_axi.arid;
                        r_ridx   <= io_axi.araddr[DEPTH_LOG2+1:2];
                        r_rlen   <= io_axi.arlen;
                        r_rburst <= io_axi.arburst;
                        r_rbeat  <= 4'd0;
                        r_rstate <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (io_axi.rready) begin
                        if (r_rbeat == r_rlen) begin
                            r_rstate <= R_IDLE;
                        end else begin
                            r_rbeat <= r_rbeat + 4'd1;
                            if (burst_steps(r_rburst)) begin
                                r_ridx <= r_ridx + IDX_ONE;
                            end
                        end
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                end
            endcase
        end
    end

    // Write FSM: accept AW, write beats, then hold the response until taken
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate <= W_IDLE;
            r_bid    <= 4'd0;
            r_widx   <= '0;
            r_wlen   <= 4'd0;
            r_wburst <= BURST_FIXED;
            r_wbeat  <= 4'd0;
            r_bresp  <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (io_axi.awvalid) begin
                        r_bid    <= io_axi.awid;
                        r_widx   <= io_axi.awaddr[DEPTH_LOG2+1:2];
                        r_wlen   <= io_axi.awlen;
                        r_wburst <= io_axi.awburst;
                        r_wbeat  <= 4'd0;
                        r_wstate <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (io_axi.wvalid) begin
                        if (io_axi.wlast || w_wbeat_last) begin
                            // Early or missing wlast ends the burst with an error
                            r_bresp  <= (io_axi.wlast != w_wbeat_last) ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end else begin
                            r_wbeat <= r_wbeat + 4'd1;
                            if (burst_steps(r_wburst)) begin
                                r_widx <= r_widx + IDX_ONE;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (io_axi.bready) begin
                        r_wstate <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    // Channel outputs are decoded from registered state only
    assign io_axi.arready = (r_rstate == R_IDLE);
    assign io_axi.rvalid  = (r_rstate == R_DATA);
    assign io_axi.rlast   = (r_rstate == R_DATA) && (r_rbeat == r_rlen);
    assign io_axi.rid     = r_rid;
    assign io_axi.rdata   = (r_rstate == R_DATA) ? w_mem_rdata : 32'h0000_0000;
    assign io_axi.rresp   = RESP_OKAY;

    assign io_axi.awready = (r_wstate == W_IDLE);
    assign io_axi.wready  = (r_wstate == W_DATA);
    assign io_axi.bvalid  = (r_wstate == W_RESP);
    assign io_axi.bid     = r_bid;
    assign io_axi.bresp   = r_bresp;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave.
module tb_axi_sram_slave;

    logic aclk;
    logic aresetn;
    int   n_chk;
    int   n_pass;

    logic [31:0] exp_rd  [16];
    logic [31:0] wr_data [16];

    axi_sram_slave_if axi ();

    axi_sram_slave #(
        .DEPTH_LOG2 (10),
        .INIT_ZERO  (1)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .io_axi  (axi.slave)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [3:0] id);
        int guard;
        @(negedge aclk);
        axi.arid    = id;
        axi.araddr  = addr;
        axi.arlen   = len;
        axi.arburst = burst;
        axi.arvalid = 1'b1;
        guard = 0;
        while (!axi.arready && guard < 50) begin
            @(posedge aclk);
            @(negedge aclk);
            guard++;
        end
        chk("ar_ready", 32'(axi.arready), 32'd1);
        @(posedge aclk);
        @(negedge aclk);
        axi.arvalid = 1'b0;
        chk("rvalid_latency", 32'(axi.rvalid), 32'd1);
    endtask

    // Starts at a negedge with rvalid expected; checks every sampled beat
    task automatic r_collect(input logic [3:0] len, input logic [3:0] id, input bit toggle);
        int n;
        int cyc;
        n = 0;
        cyc = 0;
        while (n <= int'(len) && cyc < 100) begin
            logic rdy;
            rdy = toggle ? cyc[0] : 1'b1;
            axi.rready = rdy;
            if (axi.rvalid) begin
                chk("rdata", axi.rdata, exp_rd[n]);
                chk("rlast", 32'(axi.rlast), (n == int'(len)) ? 32'd1 : 32'd0);
                chk("rid", 32'(axi.rid), 32'(id));
                if (rdy) begin
                    n++;
                end
            end
            @(posedge aclk);
            @(negedge aclk);
            cyc++;
        end
        axi.rready = 1'b0;
        chk("r_beats", 32'(n), 32'(len) + 32'd1);
        chk("r_done", 32'(axi.rvalid), 32'd0);
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [3:0] id);
        int guard;
        @(negedge aclk);
        axi.awid    = id;
        axi.awaddr  = addr;
        axi.awlen   = len;
        axi.awburst = burst;
        axi.awvalid = 1'b1;
        guard = 0;
        while (!axi.awready && guard < 50) begin
            @(posedge aclk);
            @(negedge aclk);
            guard++;
        end
        chk("aw_ready", 32'(axi.awready), 32'd1);
        @(posedge aclk);
        @(negedge aclk);
        axi.awvalid = 1'b0;
        chk("wready_after_aw", 32'(axi.wready), 32'd1);
    endtask

    task automatic w_send(input int nbeats, input int last_at, input logic [3:0] strb);
        int guard;
        for (int b = 0; b < nbeats; b++) begin
            axi.wdata  = wr_data[b];
            axi.wstrb  = strb;
            axi.wlast  = (b == last_at);
            axi.wvalid = 1'b1;
            guard = 0;
            while (!axi.wready && guard < 50) begin
                @(posedge aclk);
                @(negedge aclk);
                guard++;
            end
            chk("w_ready", 32'(axi.wready), 32'd1);
            @(posedge aclk);
            @(negedge aclk);
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
    endtask

    task automatic b_expect(input logic [1:0] resp, input logic [3:0] id, input int hold);
        int guard;
        guard = 0;
        while (!axi.bvalid && guard < 50) begin
            @(posedge aclk);
            @(negedge aclk);
            guard++;
        end
        for (int h = 0; h < hold; h++) begin
            chk("bvalid_hold", 32'(axi.bvalid), 32'd1);
            chk("bresp_hold", 32'(axi.bresp), 32'(resp));
            @(posedge aclk);
            @(negedge aclk);
        end
        chk("bvalid", 32'(axi.bvalid), 32'd1);
        chk("bresp", 32'(axi.bresp), 32'(resp));
        chk("bid", 32'(axi.bid), 32'(id));
        axi.bready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        axi.bready = 1'b0;
        chk("b_done", 32'(axi.bvalid), 32'd0);
        chk("awready_after_b", 32'(axi.awready), 32'd1);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        aresetn     = 1'b0;
        axi.arid    = 4'd0;
        axi.araddr  = 32'd0;
        axi.arlen   = 4'd0;
        axi.arburst = 2'b01;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        axi.awid    = 4'd0;
        axi.awaddr  = 32'd0;
        axi.awlen   = 4'd0;
        axi.awburst = 2'b01;
        axi.awvalid = 1'b0;
        axi.wdata   = 32'd0;
        axi.wstrb   = 4'd0;
        axi.wlast   = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;

        // Reset values
        repeat (3) @(negedge aclk);
        chk("rst_arready", 32'(axi.arready), 32'd1);
        chk("rst_awready", 32'(axi.awready), 32'd1);
        chk("rst_rvalid",  32'(axi.rvalid),  32'd0);
        chk("rst_wready",  32'(axi.wready),  32'd0);
        chk("rst_bvalid",  32'(axi.bvalid),  32'd0);
        chk("rst_rlast",   32'(axi.rlast),   32'd0);
        chk("rst_rid",     32'(axi.rid),     32'd0);
        chk("rst_bid",     32'(axi.bid),     32'd0);
        chk("rst_rdata",   axi.rdata,        32'd0);
        chk("rst_bresp",   32'(axi.bresp),   32'd0);
        aresetn = 1'b1;

        // Single write then read at 0x40
        wr_data[0] = 32'hDEAD_BEEF;
        aw_send(32'h0000_0040, 4'd0, 2'b01, 4'd5);
        w_send(1, 0, 4'hF);
        b_expect(2'b00, 4'd5, 0);
        exp_rd[0] = 32'hDEAD_BEEF;
        ar_send(32'h0000_0040, 4'd0, 2'b01, 4'd3);
        r_collect(4'd0, 4'd3, 1'b0);

        // INCR burst to words 0x40..0x43, read back with rready toggling
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hA000_0000 + 32'(i);
        aw_send(32'h0000_0100, 4'd3, 2'b01, 4'd1);
        w_send(4, 3, 4'hF);
        b_expect(2'b00, 4'd1, 0);
        for (int i = 0; i < 4; i++) exp_rd[i] = 32'hA000_0000 + 32'(i);
        ar_send(32'h0000_0100, 4'd3, 2'b01, 4'd9);
        r_collect(4'd3, 4'd9, 1'b1);

        // WRAP behaves as INCR
        ar_send(32'h0000_0104, 4'd1, 2'b10, 4'd2);
        exp_rd[0] = 32'hA000_0001;
        exp_rd[1] = 32'hA000_0002;
        r_collect(4'd1, 4'd2, 1'b0);

        // Partial strobe
        wr_data[0] = 32'h1122_3344;
        aw_send(32'h0000_0200, 4'd0, 2'b01, 4'd2);
        w_send(1, 0, 4'hF);
        b_expect(2'b00, 4'd2, 0);
        wr_data[0] = 32'hAABB_CCDD;
        aw_send(32'h0000_0200, 4'd0, 2'b01, 4'd2);
        w_send(1, 0, 4'b0101);
        b_expect(2'b00, 4'd2, 0);
        exp_rd[0] = 32'h11BB_33DD;
        ar_send(32'h0000_0200, 4'd0, 2'b01, 4'd4);
        r_collect(4'd0, 4'd4, 1'b0);

        // Early wlast: prefill four words, then len3 burst ending on beat 2
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hC000_0000 + 32'(i);
        aw_send(32'h0000_0300, 4'd3, 2'b01, 4'd6);
        w_send(4, 3, 4'hF);
        b_expect(2'b00, 4'd6, 0);
        wr_data[0] = 32'hE000_0000;
        wr_data[1] = 32'hE000_0001;
        aw_send(32'h0000_0300, 4'd3, 2'b01, 4'd12);
        w_send(2, 1, 4'hF);
        chk("wready_after_err", 32'(axi.wready), 32'd0);
        b_expect(2'b10, 4'd12, 5);
        exp_rd[0] = 32'hE000_0000;
        exp_rd[1] = 32'hE000_0001;
        exp_rd[2] = 32'hC000_0002;
        exp_rd[3] = 32'hC000_0003;
        ar_send(32'h0000_0300, 4'd3, 2'b01, 4'd0);
        r_collect(4'd3, 4'd0, 1'b0);

        // FIXED write: both beats land on one word; FIXED read repeats it
        wr_data[0] = 32'h0000_0001;
        wr_data[1] = 32'h0000_0002;
        aw_send(32'h0000_0400, 4'd1, 2'b00, 4'd7);
        w_send(2, 1, 4'hF);
        b_expect(2'b00, 4'd7, 0);
        for (int i = 0; i < 3; i++) exp_rd[i] = 32'h0000_0002;
        ar_send(32'h0000_0400, 4'd2, 2'b00, 4'd7);
        r_collect(4'd2, 4'd7, 1'b0);
        // Aliased address above the memory size reaches the same word
        ar_send(32'h0000_1400, 4'd0, 2'b01, 4'd8);
        r_collect(4'd0, 4'd8, 1'b0);

        // INCR across the top of memory wraps to word 0
        wr_data[0] = 32'h5555_0001;
        wr_data[1] = 32'h5555_0002;
        aw_send(32'h0000_0FFC, 4'd1, 2'b01, 4'd10);
        w_send(2, 1, 4'hF);
        b_expect(2'b00, 4'd10, 0);
        exp_rd[0] = 32'h5555_0002;
        ar_send(32'h0000_0000, 4'd0, 2'b01, 4'd11);
        r_collect(4'd0, 4'd11, 1'b0);
        exp_rd[0] = 32'h5555_0001;
        exp_rd[1] = 32'h5555_0002;
        ar_send(32'h0000_0FFC, 4'd1, 2'b01, 4'd11);
        r_collect(4'd1, 4'd11, 1'b0);

        // Reset in the middle of a read burst
        ar_send(32'h0000_0100, 4'd3, 2'b01, 4'd13);
        axi.rready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        axi.rready = 1'b0;
        chk("mid_rvalid", 32'(axi.rvalid), 32'd1);
        chk("mid_rdata", axi.rdata, 32'hA000_0001);
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_rvalid", 32'(axi.rvalid), 32'd0);
        chk("async_rdata", axi.rdata, 32'd0);
        chk("async_rid", 32'(axi.rid), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_arready", 32'(axi.arready), 32'd1);
        chk("post_rst_rvalid", 32'(axi.rvalid), 32'd0);
        for (int i = 0; i < 4; i++) exp_rd[i] = 32'hA000_0000 + 32'(i);
        ar_send(32'h0000_0100, 4'd3, 2'b01, 4'd14);
        r_collect(4'd3, 4'd14, 1'b0);
        exp_rd[0] = 32'hDEAD_BEEF;
        ar_send(32'h0000_0040, 4'd0, 2'b01, 4'd15);
        r_collect(4'd0, 4'd15, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, giving a memory of 2^DEPTH_LOG2 32-bit words.
REQ-002 SHALL have parameter INIT_ZERO, default 1; when 1, all memory words are 0 at time zero.
REQ-003 aclk  in  1  clock; all state changes on its rising edge.
REQ-004 aresetn  in  1  reset, asynchronous, active-low.
REQ-005 arid  in  4  read ID.
REQ-006 araddr  in  32  read byte address.
REQ-007 arlen  in  4  read beats minus 1.
REQ-008 arburst  in  2  read burst type.
REQ-009 arvalid  in  1  read-address valid.
REQ-010 arready  out  1  read-address ready.
REQ-011 rid  out  4  read ID echo.
REQ-012 rdata  out  32  read data.
REQ-013 rresp  out  2  read response, always 2'b00.
REQ-014 rlast  out  1  final read beat.
REQ-015 rvalid  out  1  read data valid.
REQ-016 rready  in  1  read data ready.
REQ-017 awid  in  4  write ID.
REQ-018 awaddr  in  32  write byte address.
REQ-019 awlen  in  4  write beats minus 1.
REQ-020 awburst  in  2  write burst type.
REQ-021 awvalid  in  1  write-address valid.
REQ-022 awready  out  1  write-address ready.
REQ-023 wdata  in  32  write data.
REQ-024 wstrb  in  4  byte enables.
REQ-025 wlast  in  1  final write beat.
REQ-026 wvalid  in  1  write data valid.
REQ-027 wready  out  1  write data ready.
REQ-028 bid  out  4  write ID echo.
REQ-029 bresp  out  2  write response.
REQ-030 bvalid  out  1  write response valid.
REQ-031 bready  in  1  write response ready.

Function
REQ-032 Read FSM SHALL use states R_IDLE and R_DATA with arready = (state == R_IDLE); an AR handshake SHALL latch arid, araddr[DEPTH_LOG2+1:2], arlen and arburst and enter R_DATA on the next cycle, giving 1-cycle AR-to-first-rvalid latency.
REQ-033 In R_DATA the block SHALL drive rvalid=1, rdata=mem[latched word index], and rlast=(beat count == latched len); rdata SHALL have no combinational path from any input.
REQ-034 On an R handshake, non-last beat: beat count +1, and word index +1 when burst != 2'b00 (FIXED), wrapping modulo depth; last beat: return to R_IDLE.
REQ-035 Write FSM SHALL use states W_IDLE, W_DATA and W_RESP with awready=(W_IDLE), wready=(W_DATA) and bvalid=(W_RESP); an AW handshake SHALL latch awid, word index, awlen and awburst.
REQ-036 Each W handshake SHALL write only the bytes enabled by wstrb at the rising edge, and SHALL advance the beat count and word index by the same rule as reads.
REQ-037 W_DATA SHALL exit to W_RESP on the first beat where wlast=1 or beat count==len; bresp SHALL be 2'b10 (SLVERR) if these disagree and 2'b00 otherwise, and bid SHALL equal the latched awid.
REQ-038 W_RESP SHALL hold bvalid and bresp stable until bready=1, then return to W_IDLE.
REQ-039 The read and write channels SHALL be fully independent; when a read and a write hit the same word in the same cycle, rdata SHALL return the pre-write value and subsequent beats SHALL return the new value.
REQ-040 Address bits above DEPTH_LOG2+1 SHALL be ignored (aliasing), and WRAP bursts (2'b10) SHALL behave as INCR.

Reset
REQ-041 While aresetn=0: both FSMs idle; arready=1, awready=1, rvalid=0, wready=0, bvalid=0, rlast=0, rid=0, bid=0, rdata=0, bresp=0; memory contents retained; reset mid-burst SHALL abort it without issuing a response.

Structure
REQ-042 FSM state encodings and AXI response codes (OKAY, SLVERR) SHALL be placed in the shared defines header.
REQ-043 The byte-writable memory array SHALL be a single sub-module, sram_bytewise (async read, 4-bit byte write enable).

Verification
REQ-044 Single write then read: AW 0x40 len0, W 0xDEADBEEF strb F -> bresp 0, bid echoed; AR 0x40 -> rdata 0xDEADBEEF, rlast=1, rvalid one cycle after AR handshake.
REQ-045 INCR read burst: AR 0x100 len3 with rready toggling -> 4 beats from words 0x40 to 0x43 in order, rlast only on the 4th beat, rdata stable while rvalid&!rready.
REQ-046 Partial strobe: memory word 0x11223344, write 0xAABBCCDD with strb 0101 -> read returns 0x11BB33DD.
REQ-047 wlast mismatch: awlen=3 with wlast on beat 2 -> exactly 2 words written, bresp=2'b10; bvalid held stable 5 cycles with bready=0.
REQ-048 Reset asserted mid read burst -> rvalid=0 asynchronously, arready=1 after release, next AR served normally, memory unchanged.
